// File: rtl/mem_read_responder.sv
// Responder side of the read_request/read_grant memory handshake with a fixed-latency internal array
// and a side write port. Optional range checking is enabled by defining MEM_RESP_RANGE_CHECK_EN.
module mem_read_responder #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_request,
   output logic              read_grant,
   input  logic [ADDR_W-1:0] addr_bus,
   output logic [DATA_W-1:0] data_bus,
   output logic              data_valid,
   output logic              read_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [2:0]        dbg_state
);

   // Handshake: the initiator holds read_request high for the whole transaction and drives addr_bus
   // while read_grant is high; data_valid is a one-cycle pulse qualifying data_bus (and read_err);
   // read_grant drops one cycle after the request drop is seen, and dropping early aborts the read.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
   localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, GRANT, WAIT, DATA, HOLD} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rd_word;
   logic              wr_ok;

   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'({1'b0, a} % DEPTH_X);
   endfunction

   assign dbg_state = state;

`ifdef MEM_RESP_RANGE_CHECK_EN
   logic rd_oor, err_q;

   assign rd_oor  = ({1'b0, addr_bus} >= DEPTH_X);
   assign wr_ok   = ({1'b0, wr_addr} < DEPTH_X);
   assign rd_word = rd_oor ? '0 : mem[to_idx(addr_bus)];

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q    <= 1'b0;
         read_err <= 1'b0;
      end else begin
         if (state == GRANT) err_q <= rd_oor;
         read_err <= (state_next == DATA) && ((state == GRANT) ? rd_oor : err_q);
      end
   end
`else
   assign wr_ok    = 1'b1;
   assign rd_word  = mem[to_idx(addr_bus)];
   assign read_err = 1'b0;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = '0;
      case (state)
         IDLE:  if (read_request) state_next = GRANT;
         GRANT: begin
            if (!read_request)   state_next = IDLE;
            else if (RD_LAT > 1) state_next = WAIT;
            else                 state_next = DATA;
         end
         WAIT: begin
            if (!read_request)          state_next = IDLE;
            else if (cnt == WAIT_LAST)  state_next = DATA;
            else                        cnt_next   = cnt + CNT_W'(1);
         end
         DATA:  state_next = HOLD;
         HOLD:  if (!read_request) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         read_grant <= 1'b0;
         data_valid <= 1'b0;
         data_bus   <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         read_grant <= (state_next != IDLE);
         data_valid <= (state_next == DATA);
         // With RD_LAT == 1 the word goes out on the capture edge itself, so bypass rdata_q.
         if (state_next == DATA) data_bus <= (state == GRANT) ? rd_word : rdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (state == GRANT) rdata_q <= rd_word;
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en && wr_ok) mem[to_idx(wr_addr)] <= wr_data;
   end

endmodule
